alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single NPC ALU between two requesters: req0 = EXU (arith/auipc/jal link), req1 = LSU address gen.
//  Round-robin grant, valid/ready handshake on each side, registered result returned to the owner.
//  Sits between the EXU/LSU and the ALU; drives ALU operands combinationally and captures alu_result.
// PARAMETERS
//  DW    32  operand/result width
//  OP_W  1   alu_op width (bit0 = add enable; one-hot, extended by later ops)
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     synchronous reset, active low
//  req0_valid    in   1     EXU request valid
//  req0_ready    out  1     EXU request accepted this cycle
//  req0_src1/src2 in  DW    EXU operands
//  req0_op       in   OP_W  EXU alu_op
//  resp0_valid   out  1     EXU result valid
//  resp0_ready   in   1     EXU takes result
//  resp0_result  out  DW    EXU result
//  req1_* / resp1_*         identical set for LSU
//  alu_src1/src2 out  DW    to shared ALU
//  alu_op        out  OP_W  to shared ALU
//  alu_result    in   DW    from shared ALU (combinational)
// BEHAVIOUR
//  - One clock; reset synchronous, active-low (rst_n sampled on posedge clk).
//  - FSM: IDLE, RESP. Reset -> IDLE, rr_ptr=0, res_q=0, owner_q=0; resp*_valid=0, resp*_result=0.
//  - IDLE: grant = only valid requester; both valid -> requester rr_ptr. reqX_ready=1 iff granted.
//    alu_* = granted request's src1/src2/op; no valid -> alu_* = 0.
//  - Fire (valid&ready) in IDLE: res_q<=alu_result, owner_q<=X, rr_ptr<=~X, -> RESP.
//  - RESP: resp{owner}_valid=1, resp*_result=res_q, other resp valid=0, both req_ready=0, alu_*=0.
//    resp fire -> IDLE next cycle. No new grant in the same cycle as resp fire.
//  - Latency: fire at cycle N -> resp_valid at N+1. Min 2 cycles per op; peak throughput 1 op / 2 cycles.
//  - Resp held stable (valid, result) while resp_ready=0; requests stall meanwhile.
//  - Requesters hold valid/src/op stable until ready; ready depends only on valids + state (no ready->valid loop).
//  - Arithmetic modulo 2^DW, no carry/overflow output. Op encoding is opaque here; passed to the ALU unchanged.
//  - rst_n low in RESP: result dropped, resp_valid=0 after that edge, rr_ptr=0.
//  - After reset, both valid on the first cycle -> req0 wins. Sustained contention alternates 0,1,0,1.
// CONFIGURATION
//  ALU_ARB_PERF_EN defined: adds outputs perf_grant0, perf_grant1, perf_stall (32 b each, saturating, reset 0).
//    grantX += 1 per fire of reqX.
//    perf_stall += 1 per cycle where some req valid and not ready.
//  Undefined: counters and their ports absent; functional behaviour identical.
// STRUCTURE
//  Package alu_pkg: DW/OP_W defaults, ALU_OP_ADD (bit0) and future one-hot op indices.
//    Also requester ID enum REQ_EXU=0/REQ_LSU=1, FSM state encoding.
//  Sub-module rr_pick2: valids[1:0] + rr_ptr -> one-hot grant; pure comb.
//  FSM, capture regs and muxes live in alu_arbiter.
// TESTING
//  1. req0 src1=5 src2=7 op=1 alone -> req0_ready same cycle; next cycle resp0_valid=1, resp0_result=12.
//  2. Both valid from reset, resp_ready=1 -> grants req0,req1,req0,req1; each resp to correct owner.
//  3. req1 0xFFFFFFFF+0x1 op=1 -> resp1_result=0. op=0 with any operands -> result 0.
//  4. resp0_ready=0 for 3 cycles, req1 valid -> resp0 stable, req1_ready=0; req1 granted 1 cycle after resp0 fire.
//  5. rst_n=0 for 1 cycle during RESP -> resp valids 0 after edge; next contention grants req0.
//  6. ALU_ARB_PERF_EN: scenario 2 for 4 ops -> perf_grant0=2, perf_grant1=2, perf_stall equals counted stall cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, one-hot ALU op
// bit indices, requester IDs, FSM state encoding.
package alu_pkg;

    localparam int DW_DEFAULT   = 32;
    localparam int OP_W_DEFAULT = 1;

    // One-hot alu_op bit positions; OP_W grows as later ops are added.
    localparam int ALU_OP_ADD = 0;
    localparam int ALU_OP_SUB = 1;
    localparam int ALU_OP_AND = 2;
    localparam int ALU_OP_OR  = 3;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_EXU) ? REQ_LSU : REQ_EXU;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone valid requester wins outright,
// under contention the requester named by rr_ptr wins. Purely combinational.
module rr_pick2
    import alu_pkg::*;
(
    input  logic [1:0] valids,
    input  req_id_e    rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valids == 2'b11) begin
            grant = (rr_ptr == REQ_EXU) ? 2'b01 : 2'b10;
        end else begin
            grant = valids;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between EXU (req0) and LSU (req1) with
// round-robin grant and a registered result. ALU_ARB_PERF_EN adds perf counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int OP_W = OP_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_src1,
    input  logic [DW-1:0]   req0_src2,
    input  logic [OP_W-1:0] req0_op,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [DW-1:0]   resp0_result,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_src1,
    input  logic [DW-1:0]   req1_src2,
    input  logic [OP_W-1:0] req1_op,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [DW-1:0]   resp1_result,
    output logic [DW-1:0]   alu_src1,
    output logic [DW-1:0]   alu_src2,
    output logic [OP_W-1:0] alu_op,
    input  logic [DW-1:0]   alu_result
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]     perf_grant0,
    output logic [31:0]     perf_grant1,
    output logic [31:0]     perf_stall
`endif
);

    arb_state_e state_q, state_d;
    req_id_e    rr_ptr_q, owner_q, fire_id;
    logic [DW-1:0] res_q;
    logic [1:0] grant;
    logic fire;
    logic resp_fire;

    rr_pick2 u_pick (
        .valids (({req1_valid, req0_valid})),
        .rr_ptr (rr_ptr_q),
        .grant  (grant)
    );

    // Ready is a function of valids and state only, so requesters never see a ready->valid loop.
    always_comb begin
        state_d     = state_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_src1    = '0;
        alu_src2    = '0;
        alu_op      = '0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        fire        = 1'b0;
        fire_id     = REQ_EXU;
        resp_fire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (grant[0]) begin
                    alu_src1 = req0_src1;
                    alu_src2 = req0_src2;
                    alu_op   = req0_op;
                end else if (grant[1]) begin
                    alu_src1 = req1_src1;
                    alu_src2 = req1_src2;
                    alu_op   = req1_op;
                end
                fire    = (req0_valid & grant[0]) | (req1_valid & grant[1]);
                fire_id = grant[1] ? REQ_LSU : REQ_EXU;
                if (fire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp0_valid = (owner_q == REQ_EXU);
                resp1_valid = (owner_q == REQ_LSU);
                resp_fire   = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);
                if (resp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp0_result = res_q;
    assign resp1_result = res_q;

    // The loser of this grant gets priority the next time both requesters contend.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= REQ_EXU;
            owner_q  <= REQ_EXU;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                res_q    <= alu_result;
                owner_q  <= fire_id;
                rr_ptr_q <= other_req(fire_id);
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic stall;
    assign stall = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (fire && (fire_id == REQ_EXU) && (perf_grant0 != '1)) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (fire && (fire_id == REQ_LSU) && (perf_grant1 != '1)) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if (stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus a scoreboard of
// expected results keyed by owner. Checks perf counters when ALU_ARB_PERF_EN is defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [31:0] req0_src1, req0_src2, resp0_result;
    logic [0:0]  req0_op;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [31:0] req1_src1, req1_src2, resp1_result;
    logic [0:0]  req1_op;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [0:0]  alu_op;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_stall;
    int          stall_model;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        owner;
        logic [31:0] res;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Stand-in for the shared ALU: bit0 of the op enables the adder.
    assign alu_result = alu_op[0] ? (alu_src1 + alu_src2) : 32'd0;

    alu_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_src1    (req0_src1),
        .req0_src2    (req0_src2),
        .req0_op      (req0_op),
        .resp0_valid  (resp0_valid),
        .resp0_ready  (resp0_ready),
        .resp0_result (resp0_result),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_src1    (req1_src1),
        .req1_src2    (req1_src2),
        .req1_op      (req1_op),
        .resp1_valid  (resp1_valid),
        .resp1_ready  (resp1_ready),
        .resp1_result (resp1_result),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_op       (alu_op),
        .alu_result   (alu_result)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0  (perf_grant0),
        .perf_grant1  (perf_grant1),
        .perf_stall   (perf_stall)
`endif
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [0:0] op);
        return op[0] ? (a + b) : 32'd0;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic id, input logic v, input logic [31:0] a,
                                  input logic [31:0] b, input logic [0:0] op);
        if (id == 1'b0) begin
            req0_valid = v; req0_src1 = a; req0_src2 = b; req0_op = op;
        end else begin
            req1_valid = v; req1_src1 = a; req1_src2 = b; req1_op = op;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input logic id, input logic [31:0] res);
        exp_t e;
        check_output("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("sb_owner", 64'(id), 64'(e.owner));
            check_output("sb_result", 64'(res), 64'(e.res));
        end
    endtask

    // Scoreboard: push on request fire, pop on response fire; reset discards pending work.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
`ifdef ALU_ARB_PERF_EN
            stall_model = 0;
`endif
        end else begin
            if (req0_valid && req0_ready) sb.push_back('{1'b0, model(req0_src1, req0_src2, req0_op)});
            if (req1_valid && req1_ready) sb.push_back('{1'b1, model(req1_src1, req1_src2, req1_op)});
            if (resp0_valid && resp0_ready) pop_check(1'b0, resp0_result);
            if (resp1_valid && resp1_ready) pop_check(1'b1, resp1_result);
`ifdef ALU_ARB_PERF_EN
            if ((req0_valid && !req0_ready) || (req1_valid && !req1_ready)) stall_model++;
`endif
        end
    end

    task automatic do_single(input logic id, input logic [31:0] a, input logic [31:0] b,
                             input logic [0:0] op, input logic [31:0] exp);
        apply_stimulus(id, 1'b1, a, b, op);
        #1;
        check_output("single_ready", 64'(id ? req1_ready : req0_ready), 64'd1);
        check_output("single_other_ready", 64'(id ? req0_ready : req1_ready), 64'd0);
        check_output("single_alu_src1", 64'(alu_src1), 64'(a));
        check_output("single_alu_op", 64'(alu_op), 64'(op));
        tick();
        apply_stimulus(id, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check_output("single_resp_valid", 64'(id ? resp1_valid : resp0_valid), 64'd1);
        check_output("single_resp_other", 64'(id ? resp0_valid : resp1_valid), 64'd0);
        check_output("single_resp_result", 64'(id ? resp1_result : resp0_result), 64'(exp));
        check_output("single_alu_idle", 64'(alu_src1), 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();

        // Reset state.
        check_output("rst_resp0_valid", 64'(resp0_valid), 64'd0);
        check_output("rst_resp1_valid", 64'(resp1_valid), 64'd0);
        check_output("rst_resp0_result", 64'(resp0_result), 64'd0);
        check_output("rst_resp1_result", 64'(resp1_result), 64'd0);
        check_output("rst_alu_src1", 64'(alu_src1), 64'd0);

        // Single EXU add: 5 + 7.
        rst_n = 1'b1;
        do_single(1'b0, 32'd5, 32'd7, 1'b1, 32'd12);

        // Sustained contention from reset alternates 0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, 32'd10, 32'd20, 1'b1);
        apply_stimulus(1'b1, 1'b1, 32'd100, 32'd200, 1'b1);
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            exp_id = (k % 2) == 1;
            #1;
            check_output("rr_req0_ready", 64'(req0_ready), 64'(!exp_id));
            check_output("rr_req1_ready", 64'(req1_ready), 64'(exp_id));
            check_output("rr_alu_src1", 64'(alu_src1), exp_id ? 64'd100 : 64'd10);
            tick();
            if (k == 3) begin
                apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
                apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
            end
            #1;
            check_output("rr_resp0_valid", 64'(resp0_valid), 64'(!exp_id));
            check_output("rr_resp1_valid", 64'(resp1_valid), 64'(exp_id));
            check_output("rr_req_stall", 64'({req0_ready, req1_ready}), 64'd0);
            check_output("rr_result", 64'(resp0_result), exp_id ? 64'd300 : 64'd30);
            tick();
        end
`ifdef ALU_ARB_PERF_EN
        check_output("perf_grant0", 64'(perf_grant0), 64'd2);
        check_output("perf_grant1", 64'(perf_grant1), 64'd2);
        check_output("perf_stall", 64'(perf_stall), 64'(stall_model));
`endif

        // Wraparound and op=0.
        do_single(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0);
        do_single(1'b0, 32'd9, 32'd9, 1'b1, 32'd18);
        do_single(1'b1, 32'h1234, 32'h5678, 1'b0, 32'd0);

        // Response back-pressure stalls the other requester.
        resp0_ready = 1'b0;
        apply_stimulus(1'b0, 1'b1, 32'd3, 32'd4, 1'b1);
        #1;
        check_output("bp_req0_ready", 64'(req0_ready), 64'd1);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 32'd50, 32'd60, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("bp_resp0_valid", 64'(resp0_valid), 64'd1);
            check_output("bp_resp0_result", 64'(resp0_result), 64'd7);
            check_output("bp_req1_ready", 64'(req1_ready), 64'd0);
            tick();
        end
        resp0_ready = 1'b1;
        #1;
        check_output("bp_resp0_release", 64'(resp0_valid), 64'd1);
        check_output("bp_req1_hold", 64'(req1_ready), 64'd0);
        tick();
        #1;
        check_output("bp_resp0_done", 64'(resp0_valid), 64'd0);
        check_output("bp_req1_granted", 64'(req1_ready), 64'd1);
        tick();
        apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check_output("bp_resp1_valid", 64'(resp1_valid), 64'd1);
        check_output("bp_resp1_result", 64'(resp1_result), 64'd110);
        tick();

        // Reset while a response is pending: result dropped, priority back to req0.
        do_single(1'b0, 32'd2, 32'd2, 1'b1, 32'd4);
        resp0_ready = 1'b0;
        apply_stimulus(1'b0, 1'b1, 32'd1, 32'd1, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check_output("rstr_resp0_pending", 64'(resp0_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        resp0_ready = 1'b1;
        check_output("rstr_resp0_valid", 64'(resp0_valid), 64'd0);
        check_output("rstr_resp1_valid", 64'(resp1_valid), 64'd0);
        check_output("rstr_result", 64'(resp0_result), 64'd0);
        apply_stimulus(1'b0, 1'b1, 32'd40, 32'd2, 1'b1);
        apply_stimulus(1'b1, 1'b1, 32'd8, 32'd8, 1'b1);
        #1;
        check_output("rstr_req0_wins", 64'(req0_ready), 64'd1);
        check_output("rstr_req1_waits", 64'(req1_ready), 64'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check_output("rstr_resp0_result", 64'(resp0_result), 64'd42);
        tick();
        tick();

        check_output("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
